// File: rtl/seg7_pkg.sv
// Shared segment constants and the BCD-to-segment lookup used by the scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Non-BCD codes (10..15) render as a dash so bad feeder data is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder with blanking and selectable output polarity.
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_ah;

    always_comb begin
        seg_ah = blank ? SEG_OFF : bcd_to_seg(bcd);
        seg    = ACTIVE_LOW ? ~seg_ah : seg_ah;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: prescaled digit scan, frame-coherent shadow capture,
// leading-zero blanking, blink and registered one-hot anode / segment outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned SCAN_HZ    = 1_000,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BLINK_HZ   = 2,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int unsigned Div   = CLK_HZ / SCAN_HZ;
    localparam int unsigned Half  = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned PreW  = $clog2(Div);
    localparam int unsigned HalfW = (Half > 1) ? $clog2(Half) : 1;
    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PreW-1:0]       PreMax  = PreW'(Div - 1);
    localparam logic [HalfW-1:0]      HalfMax = HalfW'(Half - 1);
    localparam logic [IdxW-1:0]       IdxMax  = IdxW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SegIdle = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AnIdle  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PreW-1:0]         pre_cnt_q, pre_cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [HalfW-1:0]        blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    started_q, started_d;
    logic                    frame_start_q, frame_start_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                  tick, wrap;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [3:0]            digit;
    logic                  digit_blank;
    logic                  seen_nz;

    assign tick = (pre_cnt_q == PreMax);
    assign wrap = tick && (idx_q == IdxMax);

    // Zero digits above the most significant nonzero digit; digit 0 always shows.
    always_comb begin
        seen_nz  = 1'b0;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (shadow_q[i*4 +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            lz_blank[i] = blank_lz && !seen_nz && (i != 0);
        end
    end

    always_comb begin
        digit       = 4'd0;
        digit_blank = 1'b0;
        an_sel      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                digit       = shadow_q[i*4 +: 4];
                digit_blank = lz_blank[i];
                an_sel[i]   = 1'b1;
            end
        end
    end

    // Stays dark until the first scan tick after reset.
    seg7_decoder #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_decoder (
        .bcd  (digit),
        .blank(digit_blank || !started_q),
        .seg  (seg_d)
    );

    always_comb begin
        pre_cnt_d     = tick ? '0 : pre_cnt_q + 1'b1;
        idx_d         = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        shadow_d      = wrap ? digits_in : shadow_q;
        frame_start_d = wrap;
        started_d     = started_q || tick;
        blink_cnt_d   = (blink_cnt_q == HalfMax) ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = (blink_cnt_q == HalfMax) ? ~blink_phase_q : blink_phase_q;

        // Register written on a tick edge holds the anti-ghost gap for one clock.
        if (tick || !started_q || (blink_en && !blink_phase_q)) begin
            an_d = AnIdle;
        end else begin
            an_d = ACTIVE_LOW ? ~an_sel : an_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q     <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            started_q     <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SegIdle;
            an_q          <= AnIdle;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            started_q     <= started_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign dp          = ACTIVE_LOW;
    assign frame_start = frame_start_q;

endmodule
